// File: rtl/pine16_mem_pkg.sv
// pine16_mem_pkg: bus widths, arbiter state encoding and requester IDs for the pine16 memory path.
// Latency: none (declarations only).
// Backpressure: n/a. The requester IDs match the memory controller's debug trace.
package pine16_mem_pkg;

    localparam int MEM_ADDR_W = 20;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GNT_EXU = 2'd1,
        ST_GNT_IFU = 2'd2,
        ST_DRAIN   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IFU  = 2'd1,
        REQ_EXU  = 2'd2
    } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory bus between the IFU and the EXU. EXU has priority.
// Latency: mem_req rises 1 cycle after the winning req is sampled. Acks are mem_ack passed through combinationally.
// Backpressure: requesters hold req until their ack. mem_* hold until mem_ack. At least one idle bus cycle separates transactions.
// Build option: define MEMARB_FAIR_EN to grant the IFU after STARVE_LIM EXU grants made while it waited.
// Ports: clk, rst_n (async, active low), flush (1-cycle pipeline flush);
//        ifu_req/ifu_adr -> ifu_ack/ifu_rdat; exu_req/exu_we/exu_adr/exu_wdat -> exu_ack/exu_rdat;
//        mem_req/mem_we/mem_adr/mem_wdat -> memory controller; mem_ack/mem_rdat <- memory controller.
module mem_arbiter
    import pine16_mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int STARVE_LIM = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_adr,
    output logic              ifu_ack,
    output logic [DATA_W-1:0] ifu_rdat,
    input  logic              exu_req,
    input  logic              exu_we,
    input  logic [ADDR_W-1:0] exu_adr,
    input  logic [DATA_W-1:0] exu_wdat,
    output logic              exu_ack,
    output logic [DATA_W-1:0] exu_rdat,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdat,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdat
);

    // The fairness counter is 2 bits wide, so only limits 1..3 are reachable.
    // This block elaborates only for an unusable limit and marks the misconfiguration.
    if ((STARVE_LIM < 1) || (STARVE_LIM > 3)) begin : g_starve_lim_out_of_range
    end

    arb_state_t        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [DATA_W-1:0] r_mem_wdat;

    req_id_t           w_gnt_id;
    logic              w_ifu_starved;

`ifdef MEMARB_FAIR_EN
    localparam logic [1:0] LP_STARVE_LIM = 2'(STARVE_LIM);

    logic [1:0] r_starve_cnt;

    assign w_ifu_starved = (r_starve_cnt == LP_STARVE_LIM);

    // Count EXU grants that overtook a waiting, unflushed fetch.
    // Saturate so that a long EXU burst does not wrap the count back below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= 2'd0;
        end else if (r_state == ST_IDLE) begin
            if (w_gnt_id == REQ_IFU) begin
                r_starve_cnt <= 2'd0;
            end else if ((w_gnt_id == REQ_EXU) && ifu_req && !flush &&
                         (r_starve_cnt != 2'd3)) begin
                r_starve_cnt <= r_starve_cnt + 2'd1;
            end
        end
    end
`else
    assign w_ifu_starved = 1'b0;
`endif

    // Winner for an IDLE cycle. A flush blocks a fetch grant for that cycle only.
    // A starved IFU overrides EXU priority.
    always_comb begin
        w_gnt_id = REQ_NONE;
        if (ifu_req && !flush && (w_ifu_starved || !exu_req)) begin
            w_gnt_id = REQ_IFU;
        end else if (exu_req) begin
            w_gnt_id = REQ_EXU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_wdat <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_id == REQ_EXU) begin
                        r_state    <= ST_GNT_EXU;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= exu_we;
                        r_mem_adr  <= exu_adr;
                        r_mem_wdat <= exu_wdat;
                    end else if (w_gnt_id == REQ_IFU) begin
                        r_state    <= ST_GNT_IFU;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_adr  <= ifu_adr;
                        r_mem_wdat <= '0;
                    end
                end
                ST_GNT_EXU: begin
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                ST_GNT_IFU: begin
                    // A flush that coincides with mem_ack only suppresses the ack.
                    // The fetch is complete on the bus either way.
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end else if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The bus cannot abort a request, so wait it out and drop the data.
                    if (mem_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_adr  = r_mem_adr;
    assign mem_wdat = r_mem_wdat;

    assign ifu_ack  = (r_state == ST_GNT_IFU) && mem_ack && !flush;
    assign exu_ack  = (r_state == ST_GNT_EXU) && mem_ack;
    assign ifu_rdat = mem_rdat;
    assign exu_rdat = mem_rdat;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model.
// Latency: inputs and memory responses change on negedge; outputs are sampled 3 time units after negedge.
// Backpressure: requester tasks hold req until ack and drop it on the following negedge.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          flush    = 1'b0;
    logic          ifu_req  = 1'b0;
    logic [AW-1:0] ifu_adr  = '0;
    logic          ifu_ack;
    logic [DW-1:0] ifu_rdat;
    logic          exu_req  = 1'b0;
    logic          exu_we   = 1'b0;
    logic [AW-1:0] exu_adr  = '0;
    logic [DW-1:0] exu_wdat = '0;
    logic          exu_ack;
    logic [DW-1:0] exu_rdat;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdat;
    logic          mem_ack  = 1'b0;
    logic [DW-1:0] mem_rdat = '0;

    int            n_checks = 0;
    int            n_errors = 0;
    int            mem_lat  = 1;
    logic [DW-1:0] mem_data = '0;
    int            cyc      = 0;

    typedef struct {
        logic          is_ifu;
        logic          chk_dat;
        logic [DW-1:0] dat;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        int            cyc;
    } gnt_t;

    exp_t sb_q[$];
    gnt_t gnt_log[$];
    int   n_ifu_acks        = 0;
    int   n_exu_acks        = 0;
    int   last_exu_ack_cyc  = 0;

    always #10 clk = ~clk;

    mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .ifu_req  (ifu_req),
        .ifu_adr  (ifu_adr),
        .ifu_ack  (ifu_ack),
        .ifu_rdat (ifu_rdat),
        .exu_req  (exu_req),
        .exu_we   (exu_we),
        .exu_adr  (exu_adr),
        .exu_wdat (exu_wdat),
        .exu_ack  (exu_ack),
        .exu_rdat (exu_rdat),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wdat (mem_wdat),
        .mem_ack  (mem_ack),
        .mem_rdat (mem_rdat)
    );

    // Memory: acks mem_lat negedges after it first sees mem_req, for one cycle.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_ack  = 1'b1;
                    mem_rdat = mem_data;
                    cnt      = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: logs every bus grant and checks every ack against the scoreboard.
    initial begin : monitor
        logic prev_req;
        exp_t e;
        gnt_t g;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            #3;
            if (mem_req && !prev_req) begin
                g.we = mem_we; g.adr = mem_adr; g.wdat = mem_wdat; g.cyc = cyc;
                gnt_log.push_back(g);
            end
            prev_req = mem_req;
            if (ifu_ack || exu_ack) begin
                n_checks++;
                if (ifu_ack && exu_ack) begin
                    n_errors++;
                    $display("FAIL ack_exclusive: ifu_ack=%b exu_ack=%b, required at most one high", ifu_ack, exu_ack);
                end else if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_ack: ifu_ack=%b exu_ack=%b at cycle %0d, required no ack", ifu_ack, exu_ack, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if ((e.is_ifu !== ifu_ack) ||
                        (e.chk_dat && ((ifu_ack ? ifu_rdat : exu_rdat) !== e.dat))) begin
                        n_errors++;
                        $display("FAIL sb_ack: got ifu_ack=%b rdat=%h, required is_ifu=%b rdat=%h",
                                 ifu_ack, (ifu_ack ? ifu_rdat : exu_rdat), e.is_ifu, e.dat);
                    end
                end
                if (ifu_ack) n_ifu_acks++;
                if (exu_ack) begin
                    n_exu_acks++;
                    last_exu_ack_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Call at a negedge; returns on the negedge after the ack, with req dropped.
    task automatic exu_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat);
        bit got;
        got = 1'b0;
        exu_we = we; exu_adr = adr; exu_wdat = wdat; exu_req = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #3;
            got = exu_ack;
        end
        @(negedge clk);
        exu_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL exu_ack_timeout: exu_ack=0 for 50 cycles, required 1");
        end
    endtask

    task automatic ifu_txn(input logic [AW-1:0] adr);
        bit got;
        got = 1'b0;
        ifu_adr = adr; ifu_req = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #3;
            got = ifu_ack;
        end
        @(negedge clk);
        ifu_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL ifu_ack_timeout: ifu_ack=0 for 50 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_req  !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
        n_checks++; if (mem_we   !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
        n_checks++; if (mem_adr  !== '0)   begin n_errors++; $display("FAIL reset_mem_adr: got %h, required 0", mem_adr); end
        n_checks++; if (mem_wdat !== '0)   begin n_errors++; $display("FAIL reset_mem_wdat: got %h, required 0", mem_wdat); end
        n_checks++; if (ifu_ack  !== 1'b0) begin n_errors++; $display("FAIL reset_ifu_ack: got %b, required 0", ifu_ack); end
        n_checks++; if (exu_ack  !== 1'b0) begin n_errors++; $display("FAIL reset_exu_ack: got %b, required 0", exu_ack); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_idle_req: got %b, required 0", mem_req); end
    endtask

    task automatic test_exu_read();
        int a0, i0;
        @(negedge clk);
        mem_lat = 3; mem_data = 16'hBEEF;
        a0 = n_exu_acks; i0 = n_ifu_acks;
        sb_q.push_back('{1'b0, 1'b1, 16'hBEEF});
        exu_we = 1'b0; exu_adr = 20'h12345; exu_wdat = '0; exu_req = 1'b1;
        #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL exu_rd_req_early: got %b, required 0", mem_req); end
        @(negedge clk); #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 20'h12345 || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL exu_rd_bus: got req=%b adr=%h we=%b, required 1 12345 0", mem_req, mem_adr, mem_we);
        end
        exu_txn(1'b0, 20'h12345, '0);
        repeat (3) @(negedge clk); #3;
        n_checks++; if (n_exu_acks - a0 !== 1) begin n_errors++; $display("FAIL exu_rd_ack_count: got %0d, required 1", n_exu_acks - a0); end
        n_checks++; if (n_ifu_acks != i0) begin n_errors++; $display("FAIL exu_rd_ifu_ack: got %0d, required 0", n_ifu_acks - i0); end
    endtask

    task automatic test_priority();
        int g0;
        gnt_t e0, e1;
        @(negedge clk);
        mem_lat = 2; mem_data = 16'h600D;
        g0 = gnt_log.size();
        sb_q.push_back('{1'b0, 1'b0, 16'h0000});
        sb_q.push_back('{1'b1, 1'b1, 16'h600D});
        fork
            exu_txn(1'b1, 20'h00200, 16'h5A5A);
            ifu_txn(20'h00100);
        join
        repeat (2) @(negedge clk); #3;
        n_checks++;
        if (gnt_log.size() - g0 != 2) begin
            n_errors++;
            $display("FAIL prio_grant_count: got %0d, required 2", gnt_log.size() - g0);
        end else begin
            e0 = gnt_log[g0]; e1 = gnt_log[g0 + 1];
            n_checks++;
            if (e0.we !== 1'b1 || e0.adr !== 20'h00200 || e0.wdat !== 16'h5A5A) begin
                n_errors++;
                $display("FAIL prio_first_exu: got we=%b adr=%h wdat=%h, required 1 00200 5a5a", e0.we, e0.adr, e0.wdat);
            end
            n_checks++;
            if (e1.we !== 1'b0 || e1.adr !== 20'h00100) begin
                n_errors++;
                $display("FAIL prio_second_ifu: got we=%b adr=%h, required 0 00100", e1.we, e1.adr);
            end
            n_checks++;
            if (e1.cyc - last_exu_ack_cyc != 2) begin
                n_errors++;
                $display("FAIL prio_idle_gap: ifu grant %0d cycles after exu ack, required 2", e1.cyc - last_exu_ack_cyc);
            end
        end
    endtask

    task automatic test_flush_drain();
        int i0;
        @(negedge clk);
        mem_lat = 3; mem_data = 16'hDEAD;
        i0 = n_ifu_acks;
        ifu_adr = 20'h00400; ifu_req = 1'b1;
        @(negedge clk);
        flush = 1'b1;
        #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 20'h00400) begin
            n_errors++;
            $display("FAIL drain_grant: got req=%b adr=%h, required 1 00400", mem_req, mem_adr);
        end
        @(negedge clk);
        flush = 1'b0; ifu_req = 1'b0;
        #3;
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL drain_hold_req: got %b, required 1", mem_req); end
        @(negedge clk); #3;
        n_checks++;
        if (ifu_ack !== 1'b0 || mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_ack_cycle: got ifu_ack=%b mem_req=%b, required 0 1", ifu_ack, mem_req);
        end
        @(negedge clk); #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL drain_release: got %b, required 0", mem_req); end
        repeat (2) @(negedge clk); #3;
        n_checks++; if (n_ifu_acks != i0) begin n_errors++; $display("FAIL drain_no_ack: got %0d acks, required 0", n_ifu_acks - i0); end
    endtask

    task automatic test_flush_edges();
        @(negedge clk);
        mem_lat = 2; mem_data = 16'h1357;
        ifu_adr = 20'h00800; ifu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #3;
        n_checks++; if (ifu_ack !== 1'b0) begin n_errors++; $display("FAIL flush_with_ack: got ifu_ack=%b, required 0", ifu_ack); end
        @(negedge clk);
        flush = 1'b0; ifu_req = 1'b0;
        #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL flush_with_ack_idle: got mem_req=%b, required 0", mem_req); end
        @(negedge clk);
        sb_q.push_back('{1'b1, 1'b1, 16'h1357});
        ifu_adr = 20'h00ABC; ifu_req = 1'b1; flush = 1'b1;
        #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL idle_flush_pre: got mem_req=%b, required 0", mem_req); end
        @(negedge clk);
        flush = 1'b0;
        #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL idle_flush_block: got mem_req=%b, required 0", mem_req); end
        @(negedge clk); #3;
        n_checks++;
        if (mem_req !== 1'b1 || mem_adr !== 20'h00ABC || mem_we !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_flush_next: got req=%b adr=%h we=%b, required 1 00abc 0", mem_req, mem_adr, mem_we);
        end
        ifu_txn(20'h00ABC);
    endtask

    task automatic test_async_reset();
        int a0;
        @(negedge clk);
        mem_lat = 100; mem_data = 16'hFFFF;
        a0 = n_exu_acks;
        exu_we = 1'b0; exu_adr = 20'h30000; exu_req = 1'b1;
        @(negedge clk); #3;
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL areset_pre_req: got %b, required 1", mem_req); end
        @(negedge clk); #4;
        rst_n = 1'b0; exu_req = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL areset_async_drop: got mem_req=%b, required 0", mem_req); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk); #3;
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL areset_post_req: got %b, required 0", mem_req); end
        n_checks++; if (n_exu_acks != a0) begin n_errors++; $display("FAIL areset_no_ack: got %0d acks, required 0", n_exu_acks - a0); end
        @(negedge clk);
        mem_lat = 1; mem_data = 16'h0F0F;
        sb_q.push_back('{1'b0, 1'b1, 16'h0F0F});
        exu_txn(1'b0, 20'h30000, '0);
    endtask

    task automatic test_fairness();
        int g0, n_ack;
        logic [5:0] ord;
`ifdef MEMARB_FAIR_EN
        ord = 6'b100100;
`else
        ord = 6'b000000;
`endif
        @(negedge clk);
        mem_lat = 1; mem_data = 16'hC0DE;
        for (int i = 0; i < 6; i++) sb_q.push_back('{ord[i], 1'b1, 16'hC0DE});
        g0 = gnt_log.size();
        n_ack = 0;
        ifu_adr = 20'h0AAAA; exu_we = 1'b0; exu_adr = 20'h0BBBB;
        ifu_req = 1'b1; exu_req = 1'b1;
        for (int i = 0; i < 100 && n_ack < 6; i++) begin
            @(negedge clk); #3;
            if (ifu_ack || exu_ack) n_ack++;
        end
        @(negedge clk);
        ifu_req = 1'b0; exu_req = 1'b0;
        repeat (3) @(negedge clk); #3;
        n_checks++;
        if (gnt_log.size() - g0 != 6) begin
            n_errors++;
            $display("FAIL fair_grant_count: got %0d grants, required 6", gnt_log.size() - g0);
        end
        for (int i = 0; i < 6 && (g0 + i) < gnt_log.size(); i++) begin
            n_checks++;
            if (gnt_log[g0 + i].adr !== (ord[i] ? 20'h0AAAA : 20'h0BBBB)) begin
                n_errors++;
                $display("FAIL fair_order_%0d: got adr=%h, required %h", i, gnt_log[g0 + i].adr,
                         (ord[i] ? 20'h0AAAA : 20'h0BBBB));
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_exu_read();
        test_priority();
        test_flush_drain();
        test_flush_edges();
        test_async_reset();
        test_fairness();
        repeat (2) @(negedge clk); #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drained: %0d expected acks never seen, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
